// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the seven-segment scanner.
//                State encoding, active-low segment patterns {g,f,e,d,c,b,a}
//                and digit slot indices (slot 0 = second_ones, rightmost).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Digit slot indices; an[i] drives slot i
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_display_scan_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low seven-segment decode.
//                Non-BCD codes (10..15) render as a centre dash.
//  Ports       : i_bcd [3:0]  BCD digit in
//                o_seg [6:0]  segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg7_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_scan
//  Description : Time-multiplexes the egg-timer's four BCD digits onto an
//                active-low 4-digit seven-segment display with a colon on
//                digit 2. Inputs are snapshotted once per full scan so a
//                scan never mixes two different times. When the countdown
//                stops at 00:00 the display blinks for a bounded number of
//                on/off pairs while alarm is high.
//  Ports       : clk, reset (sync, active-high)
//                enable_timer_countdown  timer core is counting
//                second_ones/tens, minute_ones/tens [3:0]  BCD time
//                an  [3:0]  digit anodes, active-low, an[0]=second_ones
//                seg [6:0]  segments {g,f,e,d,c,b,a}, active-low
//                dp         colon point, active-low, digit 2 only
//                alarm      high throughout the ALARM state
//  Options     : LEADING_ZERO_BLANK_EN - blank leading zero minute digits
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_SCANS  = 125,
    parameter int ALARM_BLINKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_timer_countdown,
    input  logic [3:0] second_ones,
    input  logic [3:0] second_tens,
    input  logic [3:0] minute_ones,
    input  logic [3:0] minute_tens,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       alarm
);

    localparam int c_div_w   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_scan_w  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS + 1) : 1;
    localparam int c_blink_w = (ALARM_BLINKS > 1) ? $clog2(ALARM_BLINKS + 1) : 1;

    logic [c_div_w-1:0]   r_div_cnt;
    logic [1:0]           r_digit_idx;
    logic [15:0]          r_snapshot;    // {min_tens, min_ones, sec_tens, sec_ones}
    state_t               r_state;
    logic [c_scan_w-1:0]  r_scan_cnt;    // scan wraps within the current blink phase
    logic [c_blink_w-1:0] r_blink_cnt;   // completed on/off pairs
    logic                 r_blink_off;

    logic       w_div_wrap;
    logic       w_scan_wrap;
    logic       w_live_zero;
    logic       w_lit;
    logic       w_blank;
    logic [3:0] w_digit;
    logic [6:0] w_dec_seg;

    assign w_div_wrap  = (r_div_cnt == c_div_w'(REFRESH_DIV - 1));
    assign w_scan_wrap = w_div_wrap && (r_digit_idx == DIG_MIN_TENS);
    assign w_live_zero = ({minute_tens, minute_ones, second_tens, second_ones} == 16'h0000);
    assign w_lit       = !((r_state == ALARM) && r_blink_off);
    assign w_digit     = r_snapshot[{r_digit_idx, 2'b00} +: 4];

    always_comb begin
        w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Colon stays lit on a blanked digit 2; only the anode is suppressed
        if ((r_digit_idx == DIG_MIN_TENS) && (r_snapshot[15:12] == 4'd0))
            w_blank = 1'b1;
        if ((r_digit_idx == DIG_MIN_ONES) && (r_snapshot[15:8] == 8'd0))
            w_blank = 1'b1;
`endif
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Scan divider, snapshot and registered display drive. Scanning keeps
    // running in the dark blink phase so the blink timebase stays intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_digit_idx <= DIG_SEC_ONES;
            r_snapshot  <= '0;
            an          <= 4'b1111;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
                if (w_scan_wrap)
                    r_snapshot <= {minute_tens, minute_ones, second_tens, second_ones};
            end else begin
                r_div_cnt <= r_div_cnt + c_div_w'(1);
            end

            an  <= (w_lit && !w_blank) ? ~(4'b0001 << r_digit_idx) : 4'b1111;
            seg <= w_blank ? SEG_OFF : w_dec_seg;
            dp  <= !(w_lit && (r_digit_idx == DIG_MIN_ONES));
        end
    end

    // Control FSM. alarm is written alongside every state change so it is
    // high exactly while the state register holds ALARM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            alarm       <= 1'b0;
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable_timer_countdown)
                        r_state <= RUN;
                end
                RUN: begin
                    // RUN is only entered with enable high, so low here is a fall
                    if (!enable_timer_countdown) begin
                        if (w_live_zero) begin
                            r_state     <= ALARM;
                            alarm       <= 1'b1;
                            r_scan_cnt  <= '0;
                            r_blink_cnt <= '0;
                            r_blink_off <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                ALARM: begin
                    if (enable_timer_countdown) begin
                        r_state <= RUN;
                        alarm   <= 1'b0;
                    end else if (w_scan_wrap) begin
                        if (r_scan_cnt == c_scan_w'(BLINK_SCANS - 1)) begin
                            r_scan_cnt  <= '0;
                            r_blink_off <= ~r_blink_off;
                            // An off->on edge closes one on/off pair
                            if (r_blink_off) begin
                                if (r_blink_cnt == c_blink_w'(ALARM_BLINKS - 1)) begin
                                    r_state <= IDLE;
                                    alarm   <= 1'b0;
                                end else begin
                                    r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
                                end
                            end
                        end else begin
                            r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule : seg7_display_scan
`default_nettype wire

// File: tb/tb_seg7_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_scan
//  Description : Directed self-checking bench for seg7_display_scan with
//                REFRESH_DIV=4, BLINK_SCANS=2, ALARM_BLINKS=2. cyc counts
//                clock edges since the last reset release; outputs seen
//                after edge cyc reflect digit slot ((cyc-1)/4)%4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_scan;

    localparam int REFRESH_DIV  = 4;
    localparam int BLINK_SCANS  = 2;
    localparam int ALARM_BLINKS = 2;

    logic       clk;
    logic       reset;
    logic       enable_timer_countdown;
    logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       alarm;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg7_display_scan #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_SCANS  (BLINK_SCANS),
        .ALARM_BLINKS (ALARM_BLINKS)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable_timer_countdown (enable_timer_countdown),
        .second_ones            (second_ones),
        .second_tens            (second_tens),
        .minute_ones            (minute_ones),
        .minute_tens            (minute_tens),
        .an                     (an),
        .seg                    (seg),
        .dp                     (dp),
        .alarm                  (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic set_time(input logic [15:0] t);
        {minute_tens, minute_ones, second_tens, second_ones} = t;
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic int scan_idx(input int c);
        return ((c - 1) / REFRESH_DIV) % 4;
    endfunction

    function automatic logic [3:0] scan_an(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << scan_idx(c));
    endfunction

    function automatic logic [3:0] digit_of(input logic [15:0] t, input int idx);
        return t[idx*4 +: 4];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        enable_timer_countdown = 1'b1;
        set_time(16'h1234);
        tick();
        tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_scan();
        logic [3:0] d;
        while (cyc < 16) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            d = digit_of(16'h1234, scan_idx(cyc));
            checks++; if (an !== scan_an(cyc)) begin failures++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, scan_an(cyc)); end
            checks++; if (seg !== dec(d)) begin failures++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, seg, dec(d)); end
            checks++; if (dp !== (scan_idx(cyc) == 2 ? 1'b0 : 1'b1)) begin failures++; $display("FAIL scan_dp cyc=%0d got=%b", cyc, dp); end
            checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL scan_alarm cyc=%0d got=%b exp=0", cyc, alarm); end
        end
    endtask

    task automatic test_snapshot();
        logic [15:0] t;
        logic [3:0]  d;
        while (cyc < 37) tick();
        second_ones = 4'd5;          // changes mid-scan while slot 1 is shown
        while (cyc < 49) begin
            tick();
            t = (cyc <= 48) ? 16'h1234 : 16'h1235;
            d = digit_of(t, scan_idx(cyc));
            checks++; if (an !== scan_an(cyc)) begin failures++; $display("FAIL snap_an cyc=%0d got=%b exp=%b", cyc, an, scan_an(cyc)); end
            checks++; if (seg !== dec(d)) begin failures++; $display("FAIL snap_seg cyc=%0d got=%b exp=%b", cyc, seg, dec(d)); end
        end
    endtask

    task automatic test_alarm_blink();
        logic       dark;
        logic [3:0] exp_an;
        logic       exp_dp;
        set_time(16'h0000);
        while (cyc < 63) tick();
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL pre_alarm got=%b exp=0", alarm); end
        enable_timer_countdown = 1'b0;
        tick();                      // edge 64: RUN -> ALARM
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_entry got=%b exp=1", alarm); end
        while (cyc < 192) begin
            tick();
            dark   = (((cyc - 65) / 32) % 2) == 1;
            exp_an = dark ? 4'b1111 : scan_an(cyc);
            exp_dp = (!dark && scan_idx(cyc) == 2) ? 1'b0 : 1'b1;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL blink_an cyc=%0d got=%b exp=%b", cyc, an, exp_an); end
            checks++; if (dp !== exp_dp) begin failures++; $display("FAIL blink_dp cyc=%0d got=%b exp=%b", cyc, dp, exp_dp); end
            checks++; if (alarm !== (cyc < 192)) begin failures++; $display("FAIL blink_alarm cyc=%0d got=%b", cyc, alarm); end
        end
        tick();
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL post_alarm_an got=%b exp=1110", an); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL post_alarm_alarm got=%b exp=0", alarm); end
    endtask

    task automatic test_alarm_exit();
        enable_timer_countdown = 1'b1;
        tick();                      // 194: IDLE -> RUN
        enable_timer_countdown = 1'b0;
        tick();                      // 195: RUN -> ALARM
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL exit_entry_alarm got=%b exp=1", alarm); end
        while (cyc < 199) tick();
        enable_timer_countdown = 1'b1;
        tick();                      // 200: ALARM -> RUN
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL exit_alarm got=%b exp=0", alarm); end
        enable_timer_countdown = 1'b0;
        tick();                      // 201: RUN -> ALARM again
        checks++; if (an !== 4'b1011) begin failures++; $display("FAIL exit_lit_an got=%b exp=1011", an); end
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL reentry_alarm got=%b exp=1", alarm); end
    endtask

    task automatic test_back_to_back_priority();
        while (cyc < 300) tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL prio_dark_an got=%b exp=1111", an); end
        while (cyc < 319) tick();
        enable_timer_countdown = 1'b1;
        tick();                      // 320: blink expiry and enable together
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL prio_alarm got=%b exp=0", alarm); end
        enable_timer_countdown = 1'b0;
        tick();                      // 321: only reaches ALARM if 320 went to RUN
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL prio_run_state alarm got=%b exp=1", alarm); end
    endtask

    task automatic test_pause();
        set_time(16'h0310);
        enable_timer_countdown = 1'b1;
        tick();                      // 322: ALARM -> RUN
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL pause_run_alarm got=%b exp=0", alarm); end
        enable_timer_countdown = 1'b0;
        tick();                      // 323: RUN -> IDLE (nonzero time)
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL pause_alarm got=%b exp=0", alarm); end
        set_time(16'h031B);
        tick();
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL pause_alarm_hold got=%b exp=0", alarm); end
        while (cyc < 337) tick();
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL dash_an got=%b exp=1110", an); end
        checks++; if (seg !== 7'b0111111) begin failures++; $display("FAIL dash_seg got=%b exp=0111111", seg); end
        while (cyc < 341) tick();
        checks++; if (seg !== 7'b1111001) begin failures++; $display("FAIL pause_sec_tens_seg got=%b exp=1111001", seg); end
        while (cyc < 345) tick();
        checks++; if (an !== 4'b1011) begin failures++; $display("FAIL pause_min_ones_an got=%b exp=1011", an); end
        checks++; if (seg !== 7'b0110000) begin failures++; $display("FAIL pause_min_ones_seg got=%b exp=0110000", seg); end
        checks++; if (dp !== 1'b0) begin failures++; $display("FAIL pause_colon got=%b exp=0", dp); end
    endtask

    task automatic test_reset_mid_alarm();
        while (cyc < 350) tick();
        set_time(16'h0000);
        enable_timer_countdown = 1'b1;
        tick();                      // 351: IDLE -> RUN
        enable_timer_countdown = 1'b0;
        tick();                      // 352: RUN -> ALARM
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL mid_entry_alarm got=%b exp=1", alarm); end
        while (cyc < 390) tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL mid_dark_an got=%b exp=1111", an); end
        reset = 1'b1;
        tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL mid_reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL mid_reset_seg got=%b exp=1111111", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL mid_reset_dp got=%b exp=1", dp); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL mid_reset_alarm got=%b exp=0", alarm); end
    endtask

    task automatic test_leading_zero();
        logic [15:0] t;
        logic        blank;
        int          idx;
        set_time(16'h0007);
        enable_timer_countdown = 1'b0;
        tick();
        reset = 1'b0;
        cyc = 0;
        while (cyc < 48) begin
            tick();
            idx = scan_idx(cyc);
            t = (cyc <= 16) ? 16'h0000 : 16'h0007;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (idx == 3 && t[15:12] == 4'd0) || (idx == 2 && t[15:8] == 8'd0);
`endif
            checks++; if (an !== (blank ? 4'b1111 : scan_an(cyc))) begin failures++; $display("FAIL lzb_an cyc=%0d got=%b blank=%b", cyc, an, blank); end
            checks++; if (dp !== (idx == 2 ? 1'b0 : 1'b1)) begin failures++; $display("FAIL lzb_dp cyc=%0d got=%b", cyc, dp); end
            if (!blank) begin
                checks++; if (seg !== dec(digit_of(t, idx))) begin failures++; $display("FAIL lzb_seg cyc=%0d got=%b exp=%b", cyc, seg, dec(digit_of(t, idx))); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_alarm_blink();
        test_alarm_exit();
        test_back_to_back_priority();
        test_pause();
        test_reset_mid_alarm();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg7_display_scan
`default_nettype wire
